// File: rtl/parking_gate_scheduler.sv
// Shared single-lane barrier arbiter: round-robin entry/exit grants, lot occupancy, abandoned-grant timeout.
// Latency: grant and gate_open rise one edge after the request is sampled; one-cycle closed guard after each grant.
// Backpressure: entry is held off while full, exit while empty; requests are levels and wait in IDLE until eligible.
module parking_gate_scheduler #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 50,
    parameter int TMR_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             enter,
    input  logic             exit,
    output logic             gate_open,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             timeout,
    output logic             error
);

    typedef enum logic [1:0] {IDLE, GRANT_IN, GRANT_OUT, CLOSE} state_t;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             last_dir_q, last_dir_d;
    logic             timeout_q, timeout_d;
    logic             error_q, error_d;
    logic             gate_open_q, gate_open_d;
    logic             entry_grant_q, entry_grant_d;
    logic             exit_grant_q, exit_grant_d;
    logic             in_ok, out_ok;

    assign full   = (count_q == CAP);
    assign empty  = (count_q == '0);
    assign in_ok  = entry_req & ~full;
    assign out_ok = exit_req & ~empty;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        timer_d    = timer_q;
        last_dir_d = last_dir_q;
        timeout_d  = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                error_d = enter | exit;
                // On a tie, serve the direction that was not served last
                if (in_ok && (!out_ok || last_dir_q == DIR_OUT)) begin
                    state_d    = GRANT_IN;
                    last_dir_d = DIR_IN;
                    timer_d    = '0;
                end else if (out_ok) begin
                    state_d    = GRANT_OUT;
                    last_dir_d = DIR_OUT;
                    timer_d    = '0;
                end
            end
            GRANT_IN: begin
                error_d = exit | (enter & full);
                if (enter && !full) begin
                    count_d = count_q + 1'b1;
                    state_d = CLOSE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = CLOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GRANT_OUT: begin
                error_d = enter | (exit & empty);
                if (exit && !empty) begin
                    count_d = count_q - 1'b1;
                    state_d = CLOSE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = CLOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CLOSE: begin
                error_d = enter | exit;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        entry_grant_d = (state_d == GRANT_IN);
        exit_grant_d  = (state_d == GRANT_OUT);
        gate_open_d   = entry_grant_d | exit_grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            timer_q       <= '0;
            last_dir_q    <= DIR_OUT;
            timeout_q     <= 1'b0;
            error_q       <= 1'b0;
            gate_open_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            last_dir_q    <= last_dir_d;
            timeout_q     <= timeout_d;
            error_q       <= error_d;
            gate_open_q   <= gate_open_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
        end
    end

    assign gate_open   = gate_open_q;
    assign entry_grant = entry_grant_q;
    assign exit_grant  = exit_grant_q;
    assign count       = count_q;
    assign timeout     = timeout_q;
    assign error       = error_q;

endmodule
